alu_exec_unit: RTL and testbench

//  Execute-stage arithmetic unit that consumes the 3-bit ALU control code from ALU control.
//  AND/OR/ADD/SUB complete in one cycle. MUL and DIV are iterative, one bit per cycle:

---
 rtl/alu_exec_unit.sv | 193 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit
//  Description : Execute-stage ALU. AND/OR/ADD/SUB and no-op codes complete
//                in one cycle. MUL (shift-add) and DIV (restoring) iterate
//                one bit per cycle, with a start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [2:0] C_OP_AND = 3'b000;
  localparam logic [2:0] C_OP_OR  = 3'b001;
  localparam logic [2:0] C_OP_ADD = 3'b010;
  localparam logic [2:0] C_OP_MUL = 3'b011;
  localparam logic [2:0] C_OP_DIV = 3'b100;
  localparam logic [2:0] C_OP_SUB = 3'b110;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  // MUL: opa = shifting multiplicand, opb = shifting multiplier, acc = product.
  // DIV: opa = dividend shifting out / quotient shifting in, opb = divisor,
  //      acc = partial remainder.
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  // One shift-add step and one restoring-divide step, from the current state.
  logic [WIDTH-1:0] w_mul_sum;
  logic [WIDTH:0]   w_rem_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_rem_sub;
  logic [WIDTH-1:0] w_rem_new;
  logic [WIDTH-1:0] w_quo_next;
  logic             w_last;

  assign w_mul_sum   = acc_q + (opb_q[0] ? opa_q : '0);
  assign w_rem_shift = {acc_q, opa_q[WIDTH-1]};
  assign w_div_ge    = (w_rem_shift >= {1'b0, opb_q});
  // When the trial subtraction succeeds the difference is below the divisor,
  // so modulo-2^WIDTH arithmetic on the low bits gives the exact remainder.
  assign w_rem_sub   = w_rem_shift[WIDTH-1:0] - opb_q;
  assign w_rem_new   = w_div_ge ? w_rem_sub : w_rem_shift[WIDTH-1:0];
  assign w_quo_next  = {opa_q[WIDTH-2:0], w_div_ge};
  assign w_last      = (cnt_q == C_CNT_LAST);

  // Next-state and datapath: dispatch in IDLE, iterate in MUL/DIV.
  always_comb begin
    logic [WIDTH-1:0] fast_res;
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    fast_res = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (alu_ctrl)
            C_OP_MUL: begin
              opa_d   = op_a;
              opb_d   = op_b;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = S_MUL;
            end
            C_OP_DIV: begin
              if (op_b == '0) begin
                result_d = '1;
                zero_d   = 1'b0;
                done_d   = 1'b1;
                dbz_d    = 1'b1;
              end else begin
                opa_d   = op_a;
                opb_d   = op_b;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_DIV;
              end
            end
            default: begin
              // Single-cycle codes; 101/111 fall through as a zero result.
              case (alu_ctrl)
                C_OP_AND: fast_res = op_a & op_b;
                C_OP_OR:  fast_res = op_a | op_b;
                C_OP_ADD: fast_res = op_a + op_b;
                C_OP_SUB: fast_res = op_a - op_b;
                default:  fast_res = '0;
              endcase
              result_d = fast_res;
              zero_d   = (fast_res == '0);
              done_d   = 1'b1;
              dbz_d    = 1'b0;
            end
          endcase
        end
      end

      S_MUL: begin
        acc_d = w_mul_sum;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (w_last) begin
          result_d = w_mul_sum;
          zero_d   = (w_mul_sum == '0);
          done_d   = 1'b1;
          dbz_d    = 1'b0;
          state_d  = S_IDLE;
        end
      end

      S_DIV: begin
        acc_d = w_rem_new;
        opa_d = w_quo_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (w_last) begin
          result_d = w_quo_next;
          zero_d   = (w_quo_next == '0);
          done_d   = 1'b1;
          dbz_d    = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-flight iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result      = result_q;
  assign zero        = zero_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_unit
//  Description : Directed self-checking bench for alu_exec_unit with a
//                cycle-level behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

  localparam int W = 32;
  localparam int LONG_LAT = W + 1;   // negedges from start to observed done

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .alu_ctrl    (alu_ctrl),
    .op_a        (op_a),
    .op_b        (op_b),
    .result      (result),
    .zero        (zero),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] fast_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      default: return '0;
    endcase
  endfunction

  logic [W-1:0] m_result;
  logic         m_zero;
  logic         m_dbz;
  logic         m_done;
  logic [W-1:0] m_pend;
  int           m_cnt;     // remaining busy cycles of a long op

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_result <= '0;
      m_zero   <= 1'b0;
      m_dbz    <= 1'b0;
      m_done   <= 1'b0;
      m_pend   <= '0;
      m_cnt    <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_result <= m_pend;
          m_zero   <= (m_pend == '0);
          m_dbz    <= 1'b0;
          m_done   <= 1'b1;
        end
      end else if (start) begin
        if (alu_ctrl == 3'b011) begin
          m_pend <= op_a * op_b;
          m_cnt  <= W;
        end else if (alu_ctrl == 3'b100) begin
          if (op_b == '0) begin
            m_result <= '1;
            m_zero   <= 1'b0;
            m_dbz    <= 1'b1;
            m_done   <= 1'b1;
          end else begin
            m_pend <= op_a / op_b;
            m_cnt  <= W;
          end
        end else begin
          m_result <= fast_op(alu_ctrl, op_a, op_b);
          m_zero   <= (fast_op(alu_ctrl, op_a, op_b) == '0);
          m_dbz    <= 1'b0;
          m_done   <= 1'b1;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("cyc_busy",   busy,        (m_cnt > 0));
    chk("cyc_done",   done,        m_done);
    chk("cyc_result", result,      m_result);
    chk("cyc_zero",   zero,        m_zero);
    chk("cyc_dbz",    div_by_zero, m_dbz);
  end

  // ---------------- directed stimulus ----------------
  // Issues one op, waits (bounded) for done and checks literal expectations.
  // Returns on the negedge where done is high, so a following call starts
  // back-to-back in the done cycle.
  task automatic run_op(input string name, input logic [2:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_r,
                        input logic exp_z, input int exp_lat);
    int lat;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_lat"},  32'(lat), 32'(exp_lat));
    chk({name, "_res"},  result,   exp_r);
    chk({name, "_zero"}, zero,     exp_z);
  endtask

  initial begin
    int n;
    int nb;
    start    = 1'b0;
    alu_ctrl = 3'b000;
    op_a     = '0;
    op_b     = '0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dbz", div_by_zero, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1
    run_op("add_5_7", 3'b010, 5, 7, 12, 1'b0, 1);
    @(negedge clk);
    chk("done_pulse_width", done, 1'b0);
    run_op("sub_9_9", 3'b110, 9, 9, 0, 1'b1, 1);
    @(negedge clk);

    // T2
    run_op("and", 3'b000, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1);
    run_op("or",  3'b001, 32'hF0F0, 32'h0FF0, 32'hFFF0, 1'b0, 1);
    run_op("sub_wrap", 3'b110, 0, 1, 32'hFFFF_FFFF, 1'b0, 1);
    run_op("nop101", 3'b101, 32'h1234, 32'h5678, 0, 1'b1, 1);
    run_op("nop111", 3'b111, 32'hFFFF, 32'h1, 0, 1'b1, 1);
    run_op("add_wrap", 3'b010, 32'hFFFF_FFFF, 2, 1, 1'b0, 1);
    @(negedge clk);

    // T3: MUL with a stray start and operand changes while busy
    alu_ctrl = 3'b011;
    op_a     = 1234;
    op_b     = 5678;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n  = 0;
    nb = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy) nb++;
      if (n == 3) begin
        start    = 1'b1;
        alu_ctrl = 3'b010;
        op_a     = 1;
        op_b     = 1;
      end else begin
        start = 1'b0;
      end
      if (n == 6) begin
        alu_ctrl = 3'b100;
        op_a     = 99;
        op_b     = 3;
      end
      @(negedge clk);
      n++;
    end
    chk("mul_busy_cycles", 32'(nb), 32'(W));
    chk("mul_res", result, 32'd7006652);
    chk("mul_done_no_busy", busy, 1'b0);
    run_op("mul_ovf", 3'b011, 32'h10000, 32'h10000, 0, 1'b1, LONG_LAT);
    run_op("mul_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0, LONG_LAT);
    @(negedge clk);

    // T4
    run_op("div_100_7", 3'b100, 100, 7, 14, 1'b0, LONG_LAT);
    run_op("div_by_0", 3'b100, 5, 0, 32'hFFFF_FFFF, 1'b0, 1);
    chk("dbz_set", div_by_zero, 1'b1);
    run_op("add_after_dbz", 3'b010, 1, 2, 3, 1'b0, 1);
    chk("dbz_clear", div_by_zero, 1'b0);
    run_op("div_max_1", 3'b100, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1'b0, LONG_LAT);
    run_op("div_small", 3'b100, 7, 100, 0, 1'b1, LONG_LAT);
    run_op("div_max_max", 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0, LONG_LAT);
    run_op("div_big", 3'b100, 32'hDEAD_BEEF, 32'h1234, 32'hDEAD_BEEF / 32'h1234, 1'b0, LONG_LAT);

    // T5: asynchronous reset in the middle of a MUL
    @(negedge clk);
    alu_ctrl = 3'b011;
    op_a     = 1234;
    op_b     = 5678;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", result, 32'h0);
    chk("arst_zero", zero, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_dbz", div_by_zero, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("add_after_rst", 3'b010, 2, 3, 5, 1'b0, 1);
    @(negedge clk);

    // T6: back-to-back, ADD issued in the DIV done cycle
    run_op("div_b2b", 3'b100, 100, 7, 14, 1'b0, LONG_LAT);
    run_op("add_b2b", 3'b010, 1, 1, 2, 1'b0, 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
